// File: rtl/booth_mult_32_pkg.sv
// booth_mult_32_pkg: shared widths, state/op encodings and Booth decode helper
package booth_mult_32_pkg;
    localparam int WIDTH = 32;
    localparam int ITERS = 32;
    localparam int CNT_W = 5;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_t;
    typedef enum logic [1:0] {BOOTH_NOP = 2'd0, BOOTH_ADD = 2'd1, BOOTH_SUB = 2'd2} booth_op_t;
    function automatic booth_op_t booth_decode(input logic [1:0] qq);
        return qq == 2'b01 ? BOOTH_ADD : qq == 2'b10 ? BOOTH_SUB : BOOTH_NOP;
    endfunction
endpackage

// File: rtl/booth_mult_32_step.sv
// booth_step: one combinational radix-2 Booth iteration on the high half
// Ports: hi current high half, m multiplicand, qq = {P[1],P[0]};
//        hi_nxt shifted high half, lo_in bit shifted into the top of LO.
module booth_step
    import booth_mult_32_pkg::*;
(
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] m,
    input  logic [1:0]       qq,
    output logic [WIDTH-1:0] hi_nxt,
    output logic             lo_in
);
    booth_op_t        op;
    logic [WIDTH-1:0] y, g, p, s;
    logic             cin, ovf, t;
    assign op  = booth_decode(qq);
    assign y   = op == BOOTH_ADD ? m : op == BOOTH_SUB ? ~m : '0;
    assign cin = op == BOOTH_SUB;
    assign g   = hi & y;
    assign p   = hi | y;
    csel_add_32 u_add (.g(g), .p(p), .cin(cin), .s(s));
    // The 33-bit true sum's sign: flip s[31] when the 32-bit add overflowed
    // (covers subtracting 0x80000000, where ~M+1 is not representable).
    assign ovf    = (hi[WIDTH-1] == y[WIDTH-1]) & (s[WIDTH-1] != hi[WIDTH-1]);
    assign t      = s[WIDTH-1] ^ ovf;
    assign hi_nxt = {t, s[WIDTH-1:1]};
    assign lo_in  = s[0];
endmodule

// File: rtl/csel_add_32.sv
// csel_add_32: 32-bit carry-select adder on generate/propagate inputs
// Ports: g = x&y, p = x|y, cin carry-in; s = x+y+cin (low 32 bits).
// Four 8-bit ripple blocks, each evaluated for both carry-ins and selected by the incoming carry.
module csel_add_32 (
    input  logic [31:0] g,
    input  logic [31:0] p,
    input  logic        cin,
    output logic [31:0] s
);
    // Half-sum bit is p & ~g, i.e. x ^ y recovered from g/p.
    function automatic logic [7:0] bsum(input logic [7:0] bg, input logic [7:0] bp, input logic c0);
        logic       c;
        logic [7:0] r;
        c = c0;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[i] = (bp[i] & ~bg[i]) ^ c;
            c    = bg[i] | (bp[i] & c);
        end
        return r;
    endfunction
    function automatic logic bcout(input logic [7:0] bg, input logic [7:0] bp, input logic c0);
        logic c;
        c = c0;
        for (int i = 0; i < 8; i++) c = bg[i] | (bp[i] & c);
        return c;
    endfunction
    logic [3:0] c;
    assign c[0] = cin;
    genvar k;
    for (k = 0; k < 4; k++) begin : g_blk
        assign s[8*k +: 8] = c[k] ? bsum(g[8*k +: 8], p[8*k +: 8], 1'b1)
                                  : bsum(g[8*k +: 8], p[8*k +: 8], 1'b0);
        if (k < 3) begin : g_c
            assign c[k+1] = c[k] ? bcout(g[8*k +: 8], p[8*k +: 8], 1'b1)
                                 : bcout(g[8*k +: 8], p[8*k +: 8], 1'b0);
        end
    end
endmodule

// File: rtl/booth_mult_32.sv
// booth_mult_32: sequential 32x32 signed radix-2 Booth multiplier
// Ports: clock, reset (async, active-high), ctrl_MULT start pulse,
//        data_operandA multiplicand, data_operandB multiplier;
//        data_result low 32 product bits, data_exception product overflows
//        signed 32 bits, data_resultRDY one-cycle done pulse.
// Option: define BOOTH_MULT_EARLY_ZERO_EN to finish in one cycle on a zero operand.
module booth_mult_32
    import booth_mult_32_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_MULT,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY
);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [2*WIDTH:0] p_q, p_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi, hi_nxt;
    logic             lo_in;
    assign hi = p_q[2*WIDTH:WIDTH+1];
    booth_step u_step (.hi(hi), .m(m_q), .qq(p_q[1:0]), .hi_nxt(hi_nxt), .lo_in(lo_in));
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            m_q     <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
        end
    end
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        if (ctrl_MULT) begin
            m_d     = data_operandA;
            p_d     = {{WIDTH{1'b0}}, data_operandB, 1'b0};
            cnt_d   = '0;
            state_d = ST_RUN;
`ifdef BOOTH_MULT_EARLY_ZERO_EN
            if (data_operandA == '0 || data_operandB == '0) begin
                p_d     = '0;
                state_d = ST_DONE;
            end
`endif
        end else begin
            case (state_q)
                ST_RUN: begin
                    p_d     = {hi_nxt, lo_in, p_q[WIDTH:1]};
                    cnt_d   = cnt_q + 1'b1;
                    state_d = cnt_q == CNT_W'(ITERS - 1) ? ST_DONE : ST_RUN;
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = state_q;
            endcase
        end
    end
    assign data_result    = p_q[WIDTH:1];
    // Overflow whenever HI is not the sign extension of LO's top bit.
    assign data_exception = ~((&hi & p_q[WIDTH]) | (~|hi & ~p_q[WIDTH]));
    assign data_resultRDY = state_q == ST_DONE;
endmodule

// File: tb/tb_booth_mult_32.sv
// tb_booth_mult_32: table-driven bench for booth_mult_32 plus abort/reset sequences
module tb_booth_mult_32;
    logic        clock = 1'b0;
    logic        reset, ctrl_MULT;
    logic [31:0] data_operandA, data_operandB, data_result;
    logic        data_exception, data_resultRDY;
    int          n_cmp = 0;
    int          n_bad = 0;

    booth_mult_32 dut (
        .clock(clock), .reset(reset), .ctrl_MULT(ctrl_MULT),
        .data_operandA(data_operandA), .data_operandB(data_operandB),
        .data_result(data_result), .data_exception(data_exception),
        .data_resultRDY(data_resultRDY)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] a, b, res;
        logic        exc;
    } vec_t;
    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    task automatic start(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        ctrl_MULT = 1'b1;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        @(negedge clock);
        ctrl_MULT = 1'b0;
    endtask

    task automatic wait_rdy(output int lat);
        lat = 0;
        while (!data_resultRDY && lat < 100) begin
            @(posedge clock);
            @(negedge clock);
            lat++;
        end
    endtask

    function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef BOOTH_MULT_EARLY_ZERO_EN
        return (a == 0 || b == 0) ? 0 : 32;
`else
        return 32;
`endif
    endfunction

    initial begin
        int  lat;
        bit  seen;
        vecs[0]  = '{32'd3,        32'd5,        32'h0000000F, 1'b0};
        vecs[1]  = '{32'hFFFFFFF9, 32'd6,        32'hFFFFFFD6, 1'b0};
        vecs[2]  = '{32'h80000000, 32'd1,        32'h80000000, 1'b0};
        vecs[3]  = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
        vecs[4]  = '{32'd65536,    32'd65536,    32'h00000000, 1'b1};
        vecs[5]  = '{32'h7FFFFFFF, 32'd2,        32'hFFFFFFFE, 1'b1};
        vecs[6]  = '{32'd0,        32'd12345,    32'h00000000, 1'b0};
        vecs[7]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0};
        vecs[8]  = '{32'h80000000, 32'h80000000, 32'h00000000, 1'b1};
        vecs[9]  = '{32'hFFFFFFFF, 32'h80000000, 32'h80000000, 1'b1};
        vecs[10] = '{32'h00001234, 32'hFFFFFFF0, 32'hFFFEDCC0, 1'b0};
        vecs[11] = '{32'd12345,    32'd0,        32'h00000000, 1'b0};

        reset = 1'b1;
        ctrl_MULT = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        #12;
        chk("reset_result", data_result, 32'h0);
        chk("reset_exc", {31'b0, data_exception}, 32'h0);
        chk("reset_rdy", {31'b0, data_resultRDY}, 32'h0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            start(vecs[i].a, vecs[i].b);
            wait_rdy(lat);
            chk($sformatf("v%0d_lat", i), lat, exp_lat(vecs[i].a, vecs[i].b));
            chk($sformatf("v%0d_result", i), data_result, vecs[i].res);
            chk($sformatf("v%0d_exc", i), {31'b0, data_exception}, {31'b0, vecs[i].exc});
            @(negedge clock);
            chk($sformatf("v%0d_rdy_drop", i), {31'b0, data_resultRDY}, 32'h0);
            chk($sformatf("v%0d_hold", i), data_result, vecs[i].res);
        end

        // Restart mid-run: the aborted 9x9 must never signal ready.
        start(32'd9, 32'd9);
        seen = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(posedge clock);
            @(negedge clock);
            seen |= data_resultRDY;
        end
        start(32'd4, 32'd4);
        seen |= data_resultRDY;
        chk("abort_no_rdy", {31'b0, seen}, 32'h0);
        wait_rdy(lat);
        chk("abort_lat", lat, 32);
        chk("abort_result", data_result, 32'd16);

        // Asynchronous reset in the middle of a run.
        start(32'd7, 32'd7);
        repeat (14) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_result", data_result, 32'h0);
        chk("midrst_exc", {31'b0, data_exception}, 32'h0);
        chk("midrst_rdy", {31'b0, data_resultRDY}, 32'h0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            @(negedge clock);
            seen |= data_resultRDY;
        end
        chk("midrst_no_rdy", {31'b0, seen}, 32'h0);
        start(32'd2, 32'd3);
        wait_rdy(lat);
        chk("post_rst_lat", lat, 32);
        chk("post_rst_result", data_result, 32'd6);
        chk("post_rst_exc", {31'b0, data_exception}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
